seq_shifter: RTL and testbench



---
 rtl/shifter_pkg.sv | 19 +
 rtl/shift_step1.sv | 42 ++++
 rtl/seq_shifter.sv | 116 +++++++++++
 tb/tb_seq_shifter.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/shifter_pkg.sv
// Shared definitions for the multi-cycle shifter: shift modes and FSM states.
package shifter_pkg;

    // Shift operation selected by the MODE input.
    typedef enum logic [1:0] {
        SH_SLL = 2'b00,   // logical left, LSB <- 0
        SH_SRL = 2'b01,   // logical right, MSB <- 0
        SH_SRA = 2'b10,   // arithmetic right, MSB kept
        SH_ROL = 2'b11    // rotate left, LSB <- old MSB
    } shift_mode_e;

    // Sequencer states.
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        FIN   = 2'b10
    } shift_state_e;

endpackage

// File: rtl/shift_step1.sv
// Combinational single-position shift/rotate step. The sequencer applies it
// once per clock, so the multi-position result is built one bit at a time.
module shift_step1
    import shifter_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] word,
    input  shift_mode_e      mode,
    output logic [WIDTH-1:0] shifted,
    output logic             carry
);

    // One-position move of the word; carry is the bit pushed out of the end.
    always_comb begin
        shifted = word;
        carry   = 1'b0;
        case (mode)
            SH_SLL: begin
                shifted = {word[WIDTH-2:0], 1'b0};
                carry   = word[WIDTH-1];
            end
            SH_SRL: begin
                shifted = {1'b0, word[WIDTH-1:1]};
                carry   = word[0];
            end
            SH_SRA: begin
                shifted = {word[WIDTH-1], word[WIDTH-1:1]};
                carry   = word[0];
            end
            SH_ROL: begin
                shifted = {word[WIDTH-2:0], word[WIDTH-1]};
                carry   = word[WIDTH-1];
            end
            default: begin
                shifted = word;
                carry   = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/seq_shifter.sv
// Multi-cycle shifter: moves the operand one position per clock for AMOUNT
// clocks, then pulses DONE with the registered result, carry-out and zero flag.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | waiting for START; result of the last operation is held
//   SHIFT | one step per edge; counter counts down to the terminal value
//   FIN   | DONE high for this single cycle; returns to IDLE on next edge
//
// The working register is driven straight onto OUTPUT, so intermediate values
// are visible while shifting. The FIN->IDLE edge never samples START, which
// gives the control unit one idle cycle before the next operation can start.
module seq_shifter
    import shifter_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int AMT_W = 4
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             START,
    input  logic [1:0]       MODE,
    input  logic [AMT_W-1:0] AMOUNT,
    input  logic [WIDTH-1:0] INPUT,
    output logic [WIDTH-1:0] OUTPUT,
    output logic             CARRY,
    output logic             ZERO,
    output logic             BUSY,
    output logic             DONE
);

    shift_state_e     state;
    shift_state_e     state_nxt;
    logic [WIDTH-1:0] work_q;
    shift_mode_e      mode_q;
    logic [AMT_W-1:0] cnt_q;
    logic             carry_q;
    logic             zero_q;
    logic [WIDTH-1:0] step_word;
    logic             step_carry;
    logic             accept;
    logic             last_step;

    shift_step1 #(
        .WIDTH (WIDTH)
    ) u_step (
        .word    (work_q),
        .mode    (mode_q),
        .shifted (step_word),
        .carry   (step_carry)
    );

    assign accept    = (state == IDLE) && START;
    assign last_step = (cnt_q == AMT_W'(1));

    // State register.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode; a zero amount skips straight to FIN.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (START) begin
                    state_nxt = (AMOUNT == '0) ? FIN : SHIFT;
                end
            end
            SHIFT: begin
                if (last_step) begin
                    state_nxt = FIN;
                end
            end
            FIN: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Operand capture on accept, one step plus counter decrement per SHIFT edge.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            work_q  <= '0;
            mode_q  <= SH_SLL;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            zero_q  <= 1'b1;
        end else if (accept) begin
            work_q  <= INPUT;
            mode_q  <= shift_mode_e'(MODE);
            cnt_q   <= AMOUNT;
            carry_q <= 1'b0;
            zero_q  <= (INPUT == '0);
        end else if (state == SHIFT) begin
            work_q  <= step_word;
            carry_q <= step_carry;
            cnt_q   <= cnt_q - AMT_W'(1);
            zero_q  <= (step_word == '0);
        end
    end

    assign OUTPUT = work_q;
    assign CARRY  = carry_q;
    assign ZERO   = zero_q;
    assign BUSY   = (state != IDLE);
    assign DONE   = (state == FIN);

endmodule

// File: tb/tb_seq_shifter.sv
// Self-checking bench for seq_shifter: directed cases plus randomized
// operations compared against an arithmetic reference model.
module tb_seq_shifter;

    localparam int W  = 16;
    localparam int AW = 5;

    logic          CLK;
    logic          RESET;
    logic          START;
    logic [1:0]    MODE;
    logic [AW-1:0] AMOUNT;
    logic [W-1:0]  INPUT;
    logic [W-1:0]  OUTPUT;
    logic          CARRY;
    logic          ZERO;
    logic          BUSY;
    logic          DONE;

    int n_checks = 0;
    int n_errors = 0;

    seq_shifter #(
        .WIDTH (W),
        .AMT_W (AW)
    ) dut (
        .CLK    (CLK),
        .RESET  (RESET),
        .START  (START),
        .MODE   (MODE),
        .AMOUNT (AMOUNT),
        .INPUT  (INPUT),
        .OUTPUT (OUTPUT),
        .CARRY  (CARRY),
        .ZERO   (ZERO),
        .BUSY   (BUSY),
        .DONE   (DONE)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: whole-word arithmetic on a wide vector; returns {carry, result}.
    function automatic logic [W:0] model(input logic [1:0] m, input int n, input logic [W-1:0] x);
        logic [63:0]        t;
        logic signed [63:0] s;
        logic [W-1:0]       r;
        logic               c;
        int                 k;
        r = '0;
        c = 1'b0;
        case (m)
            2'b00: begin
                t = {48'b0, x} << n;
                r = t[15:0];
                c = t[16];
            end
            2'b01: begin
                t = {16'b0, x, 32'b0} >> n;
                r = t[47:32];
                c = t[31];
            end
            2'b10: begin
                s = $signed({x, 48'b0}) >>> n;
                r = s[63:48];
                c = s[47];
            end
            default: begin
                k = n % W;
                r = (x << k) | (x >> (W - k));
                c = r[0];
            end
        endcase
        if (n == 0) c = 1'b0;
        return {c, r};
    endfunction

    // One complete operation with timing, result and hold checks.
    task automatic run_op(input logic [1:0] m, input int n, input logic [W-1:0] x,
                          input string tag, input bit noisy);
        logic [W:0] exp;
        int         edges;
        exp = model(m, n, x);
        @(negedge CLK);
        check({tag, "_idle_busy"}, BUSY, 0);
        START  = 1'b1;
        MODE   = m;
        AMOUNT = AW'(n);
        INPUT  = x;
        @(posedge CLK);
        #1;
        START  = 1'b0;
        MODE   = 2'($urandom);
        AMOUNT = AW'($urandom);
        INPUT  = W'($urandom);
        edges  = 0;
        @(negedge CLK);
        while (!DONE && edges < 40) begin
            check({tag, "_busy_run"}, BUSY, 1);
            if (noisy) START = 1'($urandom);
            @(negedge CLK);
            edges++;
        end
        check({tag, "_latency"}, edges, n);
        check({tag, "_done_busy"}, BUSY, 1);
        check({tag, "_out"}, OUTPUT, exp[W-1:0]);
        check({tag, "_carry"}, CARRY, exp[W]);
        check({tag, "_zero"}, ZERO, (exp[W-1:0] == '0));
        @(negedge CLK);
        START = 1'b0;
        check({tag, "_done_pulse"}, DONE, 0);
        check({tag, "_busy_end"}, BUSY, 0);
        check({tag, "_hold"}, {CARRY, OUTPUT}, exp);
    endtask

    initial begin
        RESET  = 1'b1;
        START  = 1'b0;
        MODE   = 2'b00;
        AMOUNT = '0;
        INPUT  = '0;
        #1;
        check("rst_out", OUTPUT, 0);
        check("rst_carry", CARRY, 0);
        check("rst_zero", ZERO, 1);
        check("rst_busy", BUSY, 0);
        check("rst_done", DONE, 0);
        @(negedge CLK);
        @(negedge CLK);
        RESET = 1'b0;

        run_op(2'b00, 4,  16'h00F1, "sll4", 1'b0);
        check("sll4_const", OUTPUT, 16'h0F10);
        run_op(2'b10, 1,  16'h8001, "sra1", 1'b0);
        check("sra1_const", OUTPUT, 16'hC000);
        run_op(2'b01, 15, 16'hFFFF, "srl15", 1'b0);
        check("srl15_const", OUTPUT, 16'h0001);
        run_op(2'b11, 1,  16'h8001, "rol1", 1'b0);
        check("rol1_const", OUTPUT, 16'h0003);
        run_op(2'b11, 16, 16'h1234, "rol16", 1'b0);
        check("rol16_const", OUTPUT, 16'h1234);
        run_op(2'b00, 0,  16'hABCD, "amt0", 1'b0);
        check("amt0_const", OUTPUT, 16'hABCD);
        run_op(2'b00, 16, 16'h0001, "sll16", 1'b0);
        check("sll16_zero", ZERO, 1);
        run_op(2'b10, 20, 16'h9000, "sra20", 1'b0);
        check("sra20_const", OUTPUT, 16'hFFFF);

        // START held high: second operation must not begin before E6.
        @(negedge CLK);
        START  = 1'b1;
        MODE   = 2'b00;
        AMOUNT = AW'(4);
        INPUT  = 16'h0123;
        @(posedge CLK);
        #1;
        INPUT = 16'h4007;
        repeat (4) @(posedge CLK);
        @(negedge CLK);
        check("hold_done1", DONE, 1);
        check("hold_out1", OUTPUT, 16'h1230);
        @(posedge CLK);
        @(negedge CLK);
        check("hold_idle_busy", BUSY, 0);
        check("hold_idle_out", OUTPUT, 16'h1230);
        @(posedge CLK);
        @(negedge CLK);
        check("hold_restart", BUSY, 1);
        START = 1'b0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("hold_not_yet", DONE, 0);
        @(posedge CLK);
        @(negedge CLK);
        check("hold_done2", DONE, 1);
        check("hold_out2", OUTPUT, 16'h0070);
        check("hold_carry2", CARRY, 0);
        @(negedge CLK);

        // Asynchronous reset in the middle of a shift.
        @(negedge CLK);
        START  = 1'b1;
        MODE   = 2'b00;
        AMOUNT = AW'(8);
        INPUT  = 16'h0F0F;
        @(posedge CLK);
        #1;
        START = 1'b0;
        @(posedge CLK);
        @(posedge CLK);
        #2;
        RESET = 1'b1;
        #1;
        check("arst_out", OUTPUT, 0);
        check("arst_busy", BUSY, 0);
        check("arst_zero", ZERO, 1);
        check("arst_carry", CARRY, 0);
        check("arst_done", DONE, 0);
        @(negedge CLK);
        RESET = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            check("arst_no_done", DONE, 0);
        end
        run_op(2'b01, 3, 16'h00F0, "post_rst", 1'b0);

        // Randomized operations, with START toggling while busy.
        for (int i = 0; i < 40; i++) begin
            run_op(2'($urandom), int'($urandom_range(0, 31)), W'($urandom), "rnd", 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
